reg_native_ext_mem: RTL and testbench

//  Responder end of reg_native_if: services the external-memory port (ext_req_vld/ext_ack_vld...) of a regslv block.

---
 rtl/reg_native_ext_mem_pkg.sv | 23 ++
 rtl/reg_native_ext_mem_if.sv | 35 +++
 rtl/reg_native_ext_mem_array.sv | 26 ++
 rtl/reg_native_ext_mem.sv | 127 ++++++++++++
 tb/tb_reg_native_ext_mem.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_native_ext_mem_pkg.sv
// Shared types for the reg_native external-memory responder.
// REG_NATIVE_EXT_MEM_ERR_EN selects the error-response build.
package reg_native_ext_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_e;

   localparam int LAT_CNT_W = 4;

   function automatic logic ext_err(
      input logic below_base,
      input logic past_end,
      input logic unaligned,
      input logic wr,
      input logic rd
   );
      return below_base | past_end | unaligned | (wr & rd);
   endfunction

endpackage

// File: rtl/reg_native_ext_mem_if.sv
// reg_native request/ack bundle between an initiator and the ext memory.
// ack_err exists only when REG_NATIVE_EXT_MEM_ERR_EN is defined.
interface reg_native_ext_mem_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32
);
   logic                  req_vld;
   logic                  req_rdy;
   logic                  wr_en;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  ack_vld;
   logic                  ack_rdy;
   logic [DATA_WIDTH-1:0] rd_data;
`ifdef REG_NATIVE_EXT_MEM_ERR_EN
   logic                  ack_err;
`endif

   modport master (
      output req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
      input  req_rdy, ack_vld, rd_data
`ifdef REG_NATIVE_EXT_MEM_ERR_EN
      , input ack_err
`endif
   );

   modport slave (
      input  req_vld, wr_en, rd_en, addr, wr_data, ack_rdy,
      output req_rdy, ack_vld, rd_data
`ifdef REG_NATIVE_EXT_MEM_ERR_EN
      , output ack_err
`endif
   );
endinterface

// File: rtl/reg_native_ext_mem_array.sv
// Flop word array: sync write, sync clear, combinational read mux.
module reg_native_ext_mem_array #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  clr_i,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/reg_native_ext_mem.sv
// Responder for the regslv external-memory port with programmable latency.
// Define REG_NATIVE_EXT_MEM_ERR_EN for range/alignment error responses.
module reg_native_ext_mem
   import reg_native_ext_mem_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    DEPTH      = 16,
   parameter int                    RD_LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                global_sync_reset_in,
   reg_native_ext_mem_if.slave bus
);
   localparam int OFFS_W = $clog2(DATA_WIDTH / 8);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LATENCY - 1);

   state_e                state_q, state_d;
   logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q;
   logic                  rd_ok_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  clr, accept, to_ack, rd_ok, sel_ok, err;
   logic [ADDR_WIDTH-1:0] off;
   logic [IDX_W-1:0]      idx, raddr;
   logic [DATA_WIDTH-1:0] arr_rdata;

   assign clr    = rst | global_sync_reset_in;
   assign accept = (state_q == IDLE) & bus.req_vld;
   assign to_ack = (state_d == ACK) & (state_q != ACK);

   assign off = bus.addr - BASE_ADDR;
   assign idx = IDX_W'(off >> OFFS_W);

`ifdef REG_NATIVE_EXT_MEM_ERR_EN
   localparam logic [ADDR_WIDTH-1:0] LANE_MASK =
      ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
   logic err_q;

   assign err = ext_err(bus.addr < BASE_ADDR,
                        (off >> OFFS_W) >= ADDR_WIDTH'(DEPTH),
                        |(off & LANE_MASK),
                        bus.wr_en, bus.rd_en);
`else
   assign err = 1'b0;
`endif

   // Latency-1 reads are sampled on the accept edge, before idx_q exists.
   assign rd_ok  = bus.rd_en & ~bus.wr_en & ~err;
   assign sel_ok = (state_q == IDLE) ? rd_ok : rd_ok_q;
   assign raddr  = (state_q == IDLE) ? idx : idx_q;

   reg_native_ext_mem_array #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
   ) u_array (
      .clk_i   (clk),
      .clr_i   (clr),
      .we_i    (accept & bus.wr_en & ~err),
      .waddr_i (idx),
      .wdata_i (bus.wr_data),
      .raddr_i (raddr),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (clr) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: if (bus.req_vld) begin
            cnt_d   = LAT_LOAD;
            state_d = (RD_LATENCY == 1) ? ACK : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - LAT_CNT_W'(1);
            if (cnt_d == '0) state_d = ACK;
         end
         ACK: if (bus.ack_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_rdy = (state_q == IDLE);
      bus.ack_vld = (state_q == ACK);
      bus.rd_data = (state_q == ACK) ? rdata_q : '0;
`ifdef REG_NATIVE_EXT_MEM_ERR_EN
      bus.ack_err = (state_q == ACK) & err_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         rd_ok_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            idx_q   <= idx;
            rd_ok_q <= rd_ok;
         end
         if (to_ack)
            rdata_q <= sel_ok ? arr_rdata : '0;
         else if ((state_q == ACK) & bus.ack_rdy)
            rdata_q <= '0;
      end
   end

`ifdef REG_NATIVE_EXT_MEM_ERR_EN
   always_ff @(posedge clk) begin
      if (clr)         err_q <= 1'b0;
      else if (accept) err_q <= err;
   end
`endif
endmodule

// File: tb/tb_reg_native_ext_mem.sv
// Randomized bench for reg_native_ext_mem against a word-array reference model.
// Honors REG_NATIVE_EXT_MEM_ERR_EN for error-response expectations.
module tb_reg_native_ext_mem;
   localparam int          AW    = 64;
   localparam int          DW    = 32;
   localparam int          DEPTH = 16;
   localparam int          LAT   = 2;
   localparam logic [63:0] BASE  = 64'h1000;

   logic clk = 1'b0;
   logic rst;
   logic gsr;
   int   n_chk = 0;
   int   n_pass = 0;

   logic [31:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   reg_native_ext_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   reg_native_ext_mem #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BASE_ADDR  (BASE),
      .DEPTH      (DEPTH),
      .RD_LATENCY (LAT)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .global_sync_reset_in (gsr),
      .bus                  (bus)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
   endfunction

   // Spec-level view: byte offset from BASE, 4-byte words.
   function automatic void model(input logic [63:0] a, input bit w,
                                 input bit r, input logic [31:0] wd,
                                 output logic [31:0] rd, output bit err);
      logic [63:0] off;
      logic [63:0] word;
      int          idx;
      off  = a - BASE;
      word = off / 4;
      err  = 1'b0;
`ifdef REG_NATIVE_EXT_MEM_ERR_EN
      err = (a < BASE) || (word >= DEPTH) || (off % 4 != 0) || (w && r);
`endif
      rd = '0;
      if (!err) begin
         idx = int'(word % DEPTH);
         if (w)      mem_m[idx] = wd;
         else if (r) rd = mem_m[idx];
      end
   endfunction

   task automatic txn(input logic [63:0] a, input bit w, input bit r,
                      input logic [31:0] wd, input int hold, input bit poke,
                      output logic [31:0] got);
      logic [31:0] er;
      bit          ee;
      int          k;
      logic [31:0] held;
      k = 0;
      while (!bus.req_rdy && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("req_rdy_idle", bus.req_rdy, 1);
      bus.req_vld = 1'b1;
      bus.addr    = a;
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.wr_data = wd;
      bus.ack_rdy = 1'($urandom_range(0, 1));
      model(a, w, r, wd, er, ee);
      @(posedge clk);
      @(negedge clk);
      bus.req_vld = poke;
      bus.addr    = {$urandom, $urandom};
      bus.wr_en   = 1'($urandom);
      bus.rd_en   = 1'($urandom);
      bus.wr_data = $urandom;
      // k counts posedges since (and including) the accept edge
      k = 1;
      while (!bus.ack_vld && k < 20) begin
         check("req_rdy_wait", bus.req_rdy, 0);
         @(negedge clk);
         k++;
      end
      bus.ack_rdy = 1'b0;
      check("latency", 64'(k), 64'(LAT));
      check("rd_data", bus.rd_data, er);
`ifdef REG_NATIVE_EXT_MEM_ERR_EN
      check("ack_err", bus.ack_err, ee);
`endif
      held = bus.rd_data;
      got  = bus.rd_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_vld", bus.ack_vld, 1);
         check("hold_data", bus.rd_data, held);
         check("hold_rdy", bus.req_rdy, 0);
      end
      bus.req_vld = 1'b0;
      bus.ack_rdy = 1'b1;
      @(negedge clk);
      check("post_vld", bus.ack_vld, 0);
      check("post_data", bus.rd_data, 0);
      check("post_rdy", bus.req_rdy, 1);
      bus.ack_rdy = 1'($urandom_range(0, 1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] got;
      logic [63:0] a;
      int          op, word;
      rst = 1'b1;
      gsr = 1'b0;
      bus.req_vld = 1'b0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.addr    = '0;
      bus.wr_data = '0;
      bus.ack_rdy = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_req_rdy", bus.req_rdy, 1);
      check("rst_ack_vld", bus.ack_vld, 0);
      check("rst_rd_data", bus.rd_data, 0);

      txn(BASE + 64'hC, 0, 1, '0, 0, 0, got);
      check("rst_word3", got, 32'h0);

      txn(BASE + 64'h8, 1, 0, 32'h12345678, 0, 0, got);
      txn(BASE + 64'h8, 0, 1, '0, 0, 0, got);
      check("wr_rb_lit", got, 32'h12345678);

      txn(BASE + 64'h8, 0, 1, '0, 5, 1, got);

      // soft reset while the read is still counting down
      bus.req_vld = 1'b1;
      bus.addr    = BASE + 64'h8;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b1;
      bus.ack_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_vld = 1'b0;
      gsr = 1'b1;
      @(negedge clk);
      gsr = 1'b0;
      model_clear();
      for (int i = 0; i < 6; i++) begin
         check("gsr_no_ack", bus.ack_vld, 0);
         @(negedge clk);
      end
      check("gsr_req_rdy", bus.req_rdy, 1);
      txn(BASE + 64'h8, 0, 1, '0, 0, 0, got);
      check("gsr_cleared", got, 32'h0);

      txn(BASE + 64'h4, 1, 1, 32'hFFFFFFFF, 1, 0, got);
      check("wr_rd_data", got, 32'h0);
      txn(BASE + 64'h4, 0, 1, '0, 0, 0, got);
`ifdef REG_NATIVE_EXT_MEM_ERR_EN
      check("wr_rd_dropped", got, 32'h0);
`else
      check("wr_rd_wins", got, 32'hFFFFFFFF);
`endif

      txn(BASE, 1, 0, 32'hA5A50001, 0, 0, got);
      txn(BASE + 64'(DEPTH * 4), 0, 1, '0, 0, 0, got);
`ifdef REG_NATIVE_EXT_MEM_ERR_EN
      check("oor_data", got, 32'h0);
`else
      check("alias_w0", got, 32'hA5A50001);
`endif

      for (int n = 0; n < 80; n++) begin
         op   = $urandom_range(0, 7);
         word = $urandom_range(0, 2 * DEPTH - 1);
         a    = BASE + 64'(word) * 4;
         if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 3));
         if ($urandom_range(0, 15) == 0)
            a = BASE - 64'($urandom_range(1, 4)) * 4;
         txn(a, (op == 1) || (op >= 2 && op <= 4), (op == 1) || (op >= 5),
             $urandom, $urandom_range(0, 3), 1'($urandom), got);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
